// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg
//   Shared constants and types for the tick scheduler: counter width,
//   reset divisors, the smallest legal divisor, channel count and the
//   config-port arbiter state encoding.
package tick_sched_pkg;

   localparam int CW       = 27;          // divisor / counter width
   localparam int DEF_DIV0 = 100000000;   // ch0: 1 Hz at 100 MHz
   localparam int DEF_DIV1 = 10000000;    // ch1: 10 Hz at 100 MHz
   localparam int MIN_DIV  = 2;           // smallest tick period in cycles
   localparam int NCH      = 2;           // number of channels

   typedef enum logic {
      ARB = 1'b0,   // looking for a requester to grant
      ACK = 1'b1    // acknowledging the write just taken
   } arb_state_t;

endpackage

// File: rtl/tick_chan.sv
// tick_chan
//   One scheduler channel: a 0..div-1 counter that emits a one-cycle tick
//   and toggles a square wave on every wrap. New divisors arrive through a
//   pending register and are applied only on a wrap or a clear, so the
//   output never sees a truncated or stretched period.
//
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     run        level enable; when low cnt/sq/pend hold and tick is 0
//     clr        synchronous restart; also applies a pending divisor
//     wr, wdiv   divisor write strobe and value (0/1 coerced to MIN_DIV)
//     tick       registered one-cycle pulse, raised on the wrap edge
//     sq         square wave, toggles on each wrap
//     pend       a written divisor is waiting to be applied
module tick_chan #(
   parameter int            CW      = 27,
   parameter logic [CW-1:0] DEF_DIV = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          clr,
   input  logic          wr,
   input  logic [CW-1:0] wdiv,
   output logic          tick,
   output logic          sq,
   output logic          pend
);
   import tick_sched_pkg::*;

   localparam logic [CW-1:0] MIN_D = CW'(MIN_DIV);

   logic [CW-1:0] cnt;
   logic [CW-1:0] div;
   logic [CW-1:0] pdiv;
   logic [CW-1:0] wdiv_c;
   logic          wrap;
   logic          apply;

   // div is never below MIN_D, so div-1 cannot underflow and cnt stays < div.
   assign wrap   = (cnt == div - 1'b1);
   assign apply  = pend && (clr || (run && wrap));
   assign wdiv_c = (wdiv < MIN_D) ? MIN_D : wdiv;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         div  <= DEF_DIV;
         pdiv <= DEF_DIV;
         pend <= 1'b0;
         tick <= 1'b0;
         sq   <= 1'b0;
      end else begin
         if (clr) begin
            cnt  <= '0;
            sq   <= 1'b0;
            tick <= 1'b0;
         end else if (run) begin
            tick <= wrap;
            if (wrap) begin
               cnt <= '0;
               sq  <= ~sq;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            tick <= 1'b0;
         end

         // The apply uses the value pending before this edge; a write on
         // the same edge lands in pdiv and keeps pend set.
         if (apply) begin
            div <= pdiv;
         end
         if (wr) begin
            pdiv <= wdiv_c;
            pend <= 1'b1;
         end else if (apply) begin
            pend <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/tick_sched.sv
// tick_sched
//   Two-channel programmable tick / clock-enable scheduler. ch0 drives
//   timekeeping, ch1 drives sound. Two requesters share one config write
//   port under round-robin arbitration.
//
//   Handshake: a requester holds cfg_req[r] with its cfg_chr/cfg_divr stable
//   until cfg_ack[r] pulses. The write is captured in the ARB cycle that
//   grants it; cfg_ack follows one cycle later. A req still high after the
//   ack cycle is taken as a new write.
//
//   Ports:
//     clk, rst            clock, asynchronous active-low reset
//     run[1:0], clr[1:0]  per-channel run level and restart pulse
//     cfg_req[1:0]        per-requester write request
//     cfg_ch0/cfg_div0    requester 0 target channel / divisor
//     cfg_ch1/cfg_div1    requester 1 target channel / divisor
//     cfg_ack[1:0]        one-cycle accept pulse per requester
//     tick, sq, pend      per-channel tick, square wave, pending flag
module tick_sched #(
   parameter int CW       = tick_sched_pkg::CW,
   parameter int DEF_DIV0 = tick_sched_pkg::DEF_DIV0,
   parameter int DEF_DIV1 = tick_sched_pkg::DEF_DIV1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    run,
   input  logic [1:0]    clr,
   input  logic [1:0]    cfg_req,
   input  logic          cfg_ch0,
   input  logic [CW-1:0] cfg_div0,
   input  logic          cfg_ch1,
   input  logic [CW-1:0] cfg_div1,
   output logic [1:0]    cfg_ack,
   output logic [1:0]    tick,
   output logic [1:0]    sq,
   output logic [1:0]    pend
);
   import tick_sched_pkg::*;

   arb_state_t     state_q, state_d;
   logic           rr_q, rr_d;     // requester preferred when both ask
   logic           win_q, win_d;   // requester granted, acked next cycle
   logic           sel_win;
   logic           wr_ch;
   logic [CW-1:0]  wr_div;
   logic [NCH-1:0] wr_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ARB;
         rr_q    <= 1'b0;
         win_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      win_d   = win_q;
      sel_win = 1'b0;
      wr_ch   = 1'b0;
      wr_div  = '0;
      wr_en   = '0;
      cfg_ack = '0;
      case (state_q)
         ARB: begin
            if (|cfg_req) begin
               sel_win       = (&cfg_req) ? rr_q : cfg_req[1];
               wr_ch         = sel_win ? cfg_ch1  : cfg_ch0;
               wr_div        = sel_win ? cfg_div1 : cfg_div0;
               wr_en[wr_ch]  = 1'b1;
               win_d         = sel_win;
               state_d       = ACK;
            end
         end
         ACK: begin
            cfg_ack[win_q] = 1'b1;
            rr_d           = ~win_q;
            state_d        = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      tick_chan #(
         .CW      (CW),
         .DEF_DIV ((i == 0) ? CW'(DEF_DIV0) : CW'(DEF_DIV1))
      ) u_chan (
         .clk  (clk),
         .rst  (rst),
         .run  (run[i]),
         .clr  (clr[i]),
         .wr   (wr_en[i]),
         .wdiv (wr_div),
         .tick (tick[i]),
         .sq   (sq[i]),
         .pend (pend[i])
      );
   end

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched
//   Directed bench for tick_sched with DEF_DIV0=4 and DEF_DIV1=3.
//   Timing reference: E<k> is the k-th rising edge after reset release;
//   outputs are sampled 1 ns after each edge. A channel's tick is high in
//   the cycle following the edge on which its counter wraps, and sq flips
//   on that same edge.
module tb_tick_sched;

   localparam int CW = 27;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    run, clr, cfg_req;
   logic          cfg_ch0, cfg_ch1;
   logic [CW-1:0] cfg_div0, cfg_div1;
   logic [1:0]    cfg_ack, tick, sq, pend;

   int n_checks = 0;
   int n_pass   = 0;

   tick_sched #(.CW(CW), .DEF_DIV0(4), .DEF_DIV1(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .clr      (clr),
      .cfg_req  (cfg_req),
      .cfg_ch0  (cfg_ch0),
      .cfg_div0 (cfg_div0),
      .cfg_ch1  (cfg_ch1),
      .cfg_div1 (cfg_div1),
      .cfg_ack  (cfg_ack),
      .tick     (tick),
      .sq       (sq),
      .pend     (pend)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds reset over a few edges with run=11, checks all outputs are 0,
   // releases 1 ns after an edge so the next edge is E1.
   task automatic do_reset();
      rst = 1'b0; run = 2'b11; clr = 2'b00; cfg_req = 2'b00;
      cfg_ch0 = 1'b0; cfg_ch1 = 1'b0; cfg_div0 = '0; cfg_div1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset tick", tick, 0);
      check("reset sq", sq, 0);
      check("reset pend", pend, 0);
      check("reset ack", cfg_ack, 0);
      rst = 1'b1;
   endtask

   // Steps until tick[ch] is seen; returns the number of edges taken,
   // or 999 if the budget runs out.
   task automatic wait_tick(input int ch, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (tick[ch] !== 1'b1 && n < 40);
      if (tick[ch] !== 1'b1) n = 999;
   endtask

   task automatic cfg_write(input int r, input logic ch, input logic [CW-1:0] d);
      int n;
      logic [1:0] e;
      e = 2'b00;
      e[r] = 1'b1;
      if (r == 0) begin cfg_ch0 = ch; cfg_div0 = d; end
      else        begin cfg_ch1 = ch; cfg_div1 = d; end
      cfg_req[r] = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (cfg_ack[r] !== 1'b1 && n < 8);
      check("cfg_write ack", cfg_ack, e);
      check("cfg_write latency", n, 1);
      cfg_req[r] = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0] run;
      logic [1:0] clr;
      logic [1:0] tick;
      logic [1:0] sq;
      logic [1:0] pend;
   } vec_t;

   vec_t vecs[22];

   // ---------------- test ----------------
   initial begin : main
      int n;
      int paused_ticks;

      // Rows 1..22 follow E1..E22 from reset. ch0 wraps E4,E8,E12,...;
      // ch1 wraps E3,E6,E9,E12. Rows 13-15 pause ch1 (held at cnt 0),
      // row 19 clears ch1.
      vecs[0]  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[1]  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[2]  = '{2'b11, 2'b00, 2'b10, 2'b10, 2'b00};
      vecs[3]  = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b00};
      vecs[4]  = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00};
      vecs[5]  = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b00};
      vecs[6]  = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
      vecs[7]  = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b00};
      vecs[8]  = '{2'b11, 2'b00, 2'b10, 2'b10, 2'b00};
      vecs[9]  = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b00};
      vecs[10] = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b00};
      vecs[11] = '{2'b11, 2'b00, 2'b11, 2'b01, 2'b00};
      vecs[12] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
      vecs[13] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
      vecs[14] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
      vecs[15] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b00};
      vecs[16] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[17] = '{2'b11, 2'b00, 2'b10, 2'b10, 2'b00};
      vecs[18] = '{2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
      vecs[19] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b00};
      vecs[20] = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
      vecs[21] = '{2'b11, 2'b00, 2'b10, 2'b11, 2'b00};

      rst = 1'b1; run = 2'b00; clr = 2'b00; cfg_req = 2'b00;
      cfg_ch0 = 1'b0; cfg_ch1 = 1'b0; cfg_div0 = '0; cfg_div1 = '0;
      #2;

      // 1. default periods, pause and clear from the table
      do_reset();
      for (int i = 0; i < 22; i++) begin
         run = vecs[i].run;
         clr = vecs[i].clr;
         step();
         check($sformatf("vec%0d tick", i + 1), tick, vecs[i].tick);
         check($sformatf("vec%0d sq", i + 1), sq, vecs[i].sq);
         check($sformatf("vec%0d pend", i + 1), pend, vecs[i].pend);
      end
      clr = 2'b00;

      // 2. r0 writes ch0 div=6 mid-count; old period finishes first
      do_reset();
      repeat (5) step();                 // after E5, ch0 cnt=1
      cfg_ch0 = 1'b0; cfg_div0 = 6; cfg_req = 2'b01;
      step();                            // E6: granted
      check("s2 ack", cfg_ack, 2'b01);
      check("s2 pend set", pend, 2'b01);
      cfg_req = 2'b00;
      step();                            // E7
      check("s2 ack drop", cfg_ack, 2'b00);
      check("s2 pend held", pend, 2'b01);
      step();                            // E8: wrap with old div 4
      check("s2 tick old period", tick[0], 1);
      check("s2 pend clear", pend, 2'b00);
      wait_tick(0, n); check("s2 new period a", n, 6);
      wait_tick(0, n); check("s2 new period b", n, 6);

      // 3. both requesters target ch1, rr=0; writes land E3 and E5,
      //    ch1 wraps E3 (nothing pending yet) and E6 (applies 7)
      do_reset();
      repeat (2) step();
      cfg_ch0 = 1'b1; cfg_div0 = 5; cfg_ch1 = 1'b1; cfg_div1 = 7;
      cfg_req = 2'b11;
      step();                            // E3
      check("s3 ack r0", cfg_ack, 2'b01);
      check("s3 wrap E3", tick[1], 1);
      check("s3 pend r0", pend, 2'b10);
      cfg_req[0] = 1'b0;
      step();                            // E4
      check("s3 ack gap", cfg_ack, 2'b00);
      step();                            // E5
      check("s3 ack r1", cfg_ack, 2'b10);
      check("s3 pend r1", pend, 2'b10);
      cfg_req[1] = 1'b0;
      step();                            // E6
      check("s3 wrap E6", tick[1], 1);
      check("s3 pend clear", pend, 2'b00);
      wait_tick(1, n); check("s3 period a", n, 7);
      wait_tick(1, n); check("s3 period b", n, 7);

      // 4. div=0 on ch1 is coerced to 2; sq[1] flips at E3, E5, E7
      do_reset();
      cfg_write(0, 1'b1, '0);            // granted at E1
      wait_tick(1, n); check("s4 first wrap", n, 2);
      check("s4 sq E3", sq[1], 1);
      check("s4 pend clear", pend[1], 0);
      wait_tick(1, n); check("s4 period a", n, 2);
      check("s4 sq E5", sq[1], 0);
      wait_tick(1, n); check("s4 period b", n, 2);
      check("s4 sq E7", sq[1], 1);

      // 5. pause ch0 at cnt=1 for 10 cycles, resume; then clr with pend
      do_reset();
      repeat (5) step();                 // cnt0=1, sq0=1 after E4 tick
      run = 2'b10;
      paused_ticks = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tick[0] === 1'b1) paused_ticks++;
      end
      check("s5 no tick paused", paused_ticks, 0);
      check("s5 sq held", sq[0], 1);
      run = 2'b11;
      wait_tick(0, n); check("s5 resume from held cnt", n, 3);
      wait_tick(0, n); check("s5 period after resume", n, 4);
      check("s5 sq before clr", sq[0], 1);
      cfg_write(0, 1'b0, 5);
      check("s5 pend before clr", pend, 2'b01);
      clr = 2'b01;
      step();
      clr = 2'b00;
      check("s5 clr sq", sq[0], 0);
      check("s5 clr pend", pend, 2'b00);
      check("s5 clr tick", tick[0], 0);
      wait_tick(0, n); check("s5 div applied by clr", n, 5);

      // 6. reset during ACK with pend=1, then default periods again
      do_reset();
      cfg_ch0 = 1'b0; cfg_div0 = 6; cfg_req = 2'b01;
      step();                            // E1: granted, ACK state
      check("s6 ack", cfg_ack, 2'b01);
      check("s6 pend", pend, 2'b01);
      #1 rst = 1'b0;
      #1;
      check("s6 async ack", cfg_ack, 2'b00);
      check("s6 async pend", pend, 2'b00);
      cfg_req = 2'b00;
      do_reset();
      wait_tick(0, n); check("s6 ch0 first", n, 4);
      wait_tick(0, n); check("s6 ch0 period", n, 4);
      wait_tick(1, n); check("s6 ch1 next", n, 1);
      wait_tick(1, n); check("s6 ch1 period", n, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Programmable tick/clock-enable scheduler for the 100 MHz system clock.
- Two channels: ch0 drives the clock/timekeeping control, ch1 drives sound. Each channel produces a one-cycle enable pulse and a 50%-duty square wave.
- Divisors are runtime-configurable by two requesters sharing one config write port, under round-robin arbitration.
- Updates take effect glitch-free at the channel's next wrap.

Parameters:
CW, 27, divisor/counter width
DEF_DIV0, 100000000, ch0 reset divisor (1 Hz tick)
DEF_DIV1, 10000000, ch1 reset divisor (10 Hz tick)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-low reset
run  in  2  per-channel run enable (level)
clr  in  2  per-channel synchronous restart (1-cycle pulse)
cfg_req  in  2  per-requester write request; level held until acked
cfg_ch0  in  1  requester 0 target channel
cfg_div0  in  CW  requester 0 divisor
cfg_ch1  in  1  requester 1 target channel
cfg_div1  in  CW  requester 1 divisor
cfg_ack  out  2  one-cycle grant/accept pulse per requester
tick  out  2  one-cycle enable pulse per channel
sq  out  2  square wave per channel; toggles on each tick
pend  out  2  channel has a divisor update not yet applied

Behaviour:
- Reset (rst=0, async): cnt=0, div=DEF_DIVx, pend=0, tick=0, sq=0, cfg_ack=0, rr pointer=0 (requester 0 has priority), arbiter in ARB.
- Channel counter, run=1:
  - cnt counts 0..div-1.
  - In the cycle cnt==div-1: tick=1 (registered, same cycle as wrap), sq toggles, cnt returns to 0.
  - Tick period = div cycles; sq period = 2*div cycles.
- run=0: cnt, sq and pend hold; tick=0. Resuming continues from the held cnt.
- clr=1 (any run state):
  - cnt<=0, sq<=0, tick=0 that cycle.
  - If pend=1, the pending divisor is applied immediately and pend<=0.
  - clr overrides a coincident wrap.
- Divisor rule: written values 0 and 1 are coerced to 2. The minimum tick period is 2 cycles.
- Arbiter FSM:
  - ARB: if any cfg_req is set, grant one requester. With both requesting, the grant goes to the requester selected by rr. Write div into the target channel's pending register, set pend, go to ACK.
  - ACK: assert cfg_ack[winner] for exactly 1 cycle. rr <= ~winner. Return to ARB.
  - Sustained throughput is one write per 2 cycles. A requester seeing ack must drop req or present its next write; a held req is treated as a new write.
- Pending apply:
  - Taken at the channel's next wrap cycle, while that cycle also counts with the old div.
  - In the apply cycle pend<=0 and the new div governs from cnt=0.
  - If the channel is paused, apply waits for the wrap or clr.
- Overwrite: a new write to a channel with pend=1 replaces the pending value. The last accepted write wins; no ack is lost.
- Simultaneous wrap and write to the same channel: the apply uses the value pending before that cycle. The new write stays pending (pend remains 1).
- Both requesters targeting the same channel: serialized by rr, so the second write overwrites the first.
- Counter compare uses the full CW bits. cnt never exceeds div-1, so no overflow is possible.
- Reset mid-operation aborts any pending update and any ACK in flight.

Decomposition:
- Package tick_sched_pkg: CW, DEF_DIV0/1, MIN_DIV=2, NCH=2, arbiter state encoding (ARB, ACK).
- Sub-module tick_chan, instantiated per channel. It holds cnt, div, pending register, pend, tick, sq and the run/clr/apply logic.
- The top holds the arbiter, the rr pointer and write routing.

Test Plan (DEF_DIV0=4, DEF_DIV1=3 in bench):
1. Reset release, run=2'b11 → tick[0] pulses every 4 cycles and tick[1] every 3 cycles; sq[0] period 8, sq[1] period 6; all outputs 0 during reset.
2. Requester 0 writes ch0 div=6 at mid-count → cfg_ack[0] pulses 1 cycle later and pend[0]=1. The next tick stays 4 cycles after the previous one; subsequent ticks are 6 apart and pend[0] then clears.
3. Both requesters assert together (r0→ch1 div=5, r1→ch1 div=7), rr=0 → r0 acked first and r1 two cycles later; ch1 settles to period 7 and never uses 5 if both land before the wrap.
4. Write div=0 to ch1 → ch1 tick period becomes 2 and sq[1] toggles every 2 cycles.
5. run[0]=0 for 10 cycles mid-count, then 1 → no tick[0] while paused and the count resumes from the held value. A clr[0] with pend=1 → cnt=0 and sq=0, the new div is applied at once and pend[0]=0.
6. rst asserted during ACK with pend=1 → cfg_ack=0, pend=0 and div returns to default asynchronously; normal 4/3 ticks resume after release.
